// File: rtl/bus_responder_if.sv
// Bus from a 16-bit-address CPU to bus_responder: request, direction, address and write data
// go out from the master; read data and the completion/error strobes come back.
interface bus_responder_if;
  logic        req;
  logic        rw;
  logic [15:0] addr;
  logic [7:0]  wdata;
  logic [7:0]  rdata;
  logic        ready;
  logic        bus_err;

  modport master (output req, rw, addr, wdata, input  rdata, ready, bus_err);
  modport slave  (input  req, rw, addr, wdata, output rdata, ready, bus_err);
endinterface

// File: rtl/bus_responder.sv
// Wait-stated bus responder: byte RAM at 0x0000, vector words at 0xFFFA-0xFFFF, open-bus 0xEA
// elsewhere; defining BUS_RESPONDER_IO_PORT_EN adds an output port register at 0x8000.
module bus_responder #(
  parameter int unsigned RAM_AWIDTH  = 11,
  parameter int unsigned WAIT_CYCLES = 1,
  parameter logic [15:0] RESET_VEC   = 16'hF000,
  parameter logic [15:0] NMI_VEC     = 16'hF000,
  parameter logic [15:0] IRQ_VEC     = 16'hF000
) (
  input  logic           ph1,
  input  logic           reset,
  bus_responder_if.slave bus,
  output logic [7:0]     io_data,
  output logic           io_strobe
);

`ifdef BUS_RESPONDER_IO_PORT_EN
  localparam bit IO_EN = 1'b1;
`else
  localparam bit IO_EN = 1'b0;
`endif

  localparam int unsigned RAM_BYTES = 1 << RAM_AWIDTH;
  localparam logic [15:0] IO_ADDR   = 16'h8000;
  localparam logic [7:0]  OPEN_BUS  = 8'hEA;
  localparam logic [3:0]  WAIT_INIT = (WAIT_CYCLES == 0) ? 4'd0 : 4'(WAIT_CYCLES - 1);

  typedef enum logic [1:0] { S_IDLE, S_WAIT, S_RESP } state_e;

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        rw_q, rw_d;
  logic [15:0] addr_q, addr_d;
  logic [7:0]  wdata_q, wdata_d;
  logic [7:0]  rdata_q, rdata_d;
  logic        bus_err_q, bus_err_d;
  logic [7:0]  io_data_q, io_data_d;
  logic        io_strobe_q, io_strobe_d;

  logic [7:0]  ram_q [RAM_BYTES];
  logic        ram_we;
  logic        accept, enter_resp;
  logic        hit_ram, hit_vec, hit_io;
  logic [15:0] vec_word;
  logic [7:0]  rd_byte;

  // addr_d is the access being captured this edge (or the held one), so with zero wait states
  // the response is decoded from the same sample that is latched, never from later bus activity.
  always_comb begin
    accept  = (state_q == S_IDLE) && bus.req;
    rw_d    = accept ? bus.rw    : rw_q;
    addr_d  = accept ? bus.addr  : addr_q;
    wdata_d = accept ? bus.wdata : wdata_q;
  end

  always_comb begin
    hit_ram = ((32'(addr_d) >> RAM_AWIDTH) == 32'd0);
    hit_vec = (addr_d >= 16'hFFFA);
    hit_io  = IO_EN && (addr_d == IO_ADDR);
    case (addr_d[2:1])
      2'b01:   vec_word = NMI_VEC;
      2'b10:   vec_word = RESET_VEC;
      default: vec_word = IRQ_VEC;
    endcase
    if (hit_ram)      rd_byte = ram_q[addr_d[RAM_AWIDTH-1:0]];
    else if (hit_vec) rd_byte = addr_d[0] ? vec_word[15:8] : vec_word[7:0];
    else if (hit_io)  rd_byte = io_data_q;
    else              rd_byte = OPEN_BUS;
  end

  // NOTE: every signal written in this block gets a default first, so no path can infer a latch.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    enter_resp  = 1'b0;
    ram_we      = 1'b0;
    rdata_d     = rdata_q;
    bus_err_d   = 1'b0;
    io_data_d   = io_data_q;
    io_strobe_d = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (accept) begin
          if (WAIT_CYCLES == 0) begin
            state_d    = S_RESP;
            enter_resp = 1'b1;
          end else begin
            state_d = S_WAIT;
            cnt_d   = WAIT_INIT;
          end
        end
      end
      S_WAIT: begin
        if (cnt_q == 4'd0) begin
          state_d    = S_RESP;
          enter_resp = 1'b1;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      S_RESP: begin
        state_d = S_IDLE;
        if (!rw_q) begin
          ram_we = hit_ram;
          if (hit_io) begin
            io_data_d   = wdata_q;
            io_strobe_d = 1'b1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
    if (enter_resp) begin
      bus_err_d = rw_d ? !(hit_ram || hit_vec || hit_io) : !(hit_ram || hit_io);
      if (rw_d) rdata_d = rd_byte;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge ph1) begin
    if (reset) begin
      state_q     <= S_IDLE;
      cnt_q       <= 4'd0;
      rw_q        <= 1'b1;
      addr_q      <= 16'h0000;
      wdata_q     <= 8'h00;
      rdata_q     <= 8'h00;
      bus_err_q   <= 1'b0;
      io_data_q   <= 8'h00;
      io_strobe_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      rw_q        <= rw_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      rdata_q     <= rdata_d;
      bus_err_q   <= bus_err_d;
      io_data_q   <= io_data_d;
      io_strobe_q <= io_strobe_d;
    end
  end

  // NOTE: the RAM array is deliberately not reset; reset only blocks a write landing on that edge.
  always_ff @(posedge ph1) begin
    if (ram_we && !reset) ram_q[addr_q[RAM_AWIDTH-1:0]] <= wdata_q;
  end

  assign bus.rdata   = rdata_q;
  assign bus.ready   = (state_q == S_RESP);
  assign bus.bus_err = bus_err_q;
  assign io_data     = io_data_q;
  assign io_strobe   = io_strobe_q;

endmodule

// File: tb/tb_bus_responder.sv
// Directed bench for bus_responder: three instances (1, 3 and 0 wait states) driven one at a
// time, with a queue of expected responses checked when each ready strobe appears.
module tb_bus_responder;

  typedef struct packed {
    logic [7:0] rdata;
    logic       err;
  } exp_t;

  logic ph1 = 1'b0;
  always #5 ph1 = ~ph1;

  // index 0: WAIT_CYCLES=1 defaults, 1: WAIT_CYCLES=3, 2: WAIT_CYCLES=0 with distinct vectors
  logic        rst_s   [3];
  logic        req_s   [3];
  logic        rw_s    [3];
  logic [15:0] addr_s  [3];
  logic [7:0]  wdata_s [3];
  logic [7:0]  rdata_s [3];
  logic        ready_s [3];
  logic        err_s   [3];
  logic [7:0]  iod_s   [3];
  logic        ios_s   [3];

  bus_responder_if bif0();
  bus_responder_if bif1();
  bus_responder_if bif2();

  assign bif0.req   = req_s[0];
  assign bif0.rw    = rw_s[0];
  assign bif0.addr  = addr_s[0];
  assign bif0.wdata = wdata_s[0];
  assign rdata_s[0] = bif0.rdata;
  assign ready_s[0] = bif0.ready;
  assign err_s[0]   = bif0.bus_err;

  assign bif1.req   = req_s[1];
  assign bif1.rw    = rw_s[1];
  assign bif1.addr  = addr_s[1];
  assign bif1.wdata = wdata_s[1];
  assign rdata_s[1] = bif1.rdata;
  assign ready_s[1] = bif1.ready;
  assign err_s[1]   = bif1.bus_err;

  assign bif2.req   = req_s[2];
  assign bif2.rw    = rw_s[2];
  assign bif2.addr  = addr_s[2];
  assign bif2.wdata = wdata_s[2];
  assign rdata_s[2] = bif2.rdata;
  assign ready_s[2] = bif2.ready;
  assign err_s[2]   = bif2.bus_err;

  bus_responder #(.WAIT_CYCLES(1)) dut_w1 (
    .ph1(ph1), .reset(rst_s[0]), .bus(bif0), .io_data(iod_s[0]), .io_strobe(ios_s[0])
  );

  bus_responder #(.WAIT_CYCLES(3)) dut_w3 (
    .ph1(ph1), .reset(rst_s[1]), .bus(bif1), .io_data(iod_s[1]), .io_strobe(ios_s[1])
  );

  bus_responder #(
    .WAIT_CYCLES(0), .RESET_VEC(16'h1234), .NMI_VEC(16'h5678), .IRQ_VEC(16'h9ABC)
  ) dut_w0 (
    .ph1(ph1), .reset(rst_s[2]), .bus(bif2), .io_data(iod_s[2]), .io_strobe(ios_s[2])
  );

  int         n_cmp = 0;
  int         n_err = 0;
  exp_t       sb_q[$];
  logic [7:0] last_rd    [3];
  int         strobe_cnt [3];

  initial begin
    for (int k = 0; k < 3; k++) strobe_cnt[k] = 0;
  end

  always @(negedge ph1) begin
    for (int k = 0; k < 3; k++) if (ios_s[k] === 1'b1) strobe_cnt[k]++;
  end

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Called at a negedge with instance k idle; returns at a negedge with it idle again.
  task automatic access(input int k, input logic rw, input logic [15:0] a, input logic [7:0] wd,
                        input logic [7:0] exp_rd, input logic exp_err, input int exp_lat,
                        input logic exp_stb, input string tag);
    exp_t e;
    int   lat;
    req_s[k]   = 1'b1;
    rw_s[k]    = rw;
    addr_s[k]  = a;
    wdata_s[k] = wd;
    e.rdata = rw ? exp_rd : last_rd[k];
    e.err   = exp_err;
    sb_q.push_back(e);
    if (rw) last_rd[k] = exp_rd;
    @(posedge ph1);
    #1;
    // drop the request and scramble the bus: the captured access must still complete unchanged
    req_s[k]   = 1'b0;
    rw_s[k]    = ~rw;
    addr_s[k]  = ~a;
    wdata_s[k] = ~wd;
    lat = 0;
    for (int n = 1; n <= 20; n++) begin
      @(negedge ph1);
      if (ready_s[k] === 1'b1) begin
        lat = n;
        break;
      end
    end
    check({tag, " latency"}, 16'(lat), 16'(exp_lat));
    if (lat != 0) begin
      check({tag, " sb_nonempty"}, 16'(sb_q.size() > 0), 16'd1);
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        check({tag, " rdata"}, 16'(rdata_s[k]), 16'(e.rdata));
        check({tag, " bus_err"}, 16'(err_s[k]), 16'(e.err));
      end
      check({tag, " strobe_in_resp"}, 16'(ios_s[k]), 16'd0);
    end
    @(negedge ph1);
    check({tag, " ready_1cyc"}, 16'(ready_s[k]), 16'd0);
    check({tag, " err_1cyc"}, 16'(err_s[k]), 16'd0);
    check({tag, " strobe_after"}, 16'(ios_s[k]), 16'(exp_stb));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed no finish, expected finish before 200000");
    $fatal(1, "watchdog expired");
  end

  logic [15:0] vaddr [6];
  logic [7:0]  vdat  [6];
  int          rdy_cnt;
  int          idx;
  exp_t        e;

  initial begin
    vaddr[0] = 16'hFFFA; vdat[0] = 8'h78;
    vaddr[1] = 16'hFFFB; vdat[1] = 8'h56;
    vaddr[2] = 16'hFFFC; vdat[2] = 8'h34;
    vaddr[3] = 16'hFFFD; vdat[3] = 8'h12;
    vaddr[4] = 16'hFFFE; vdat[4] = 8'hBC;
    vaddr[5] = 16'hFFFF; vdat[5] = 8'h9A;

    // Reset with a write request present in the same cycles: reset must win.
    for (int k = 0; k < 3; k++) begin
      rst_s[k]   = 1'b1;
      req_s[k]   = 1'b1;
      rw_s[k]    = 1'b0;
      addr_s[k]  = 16'h8000;
      wdata_s[k] = 8'hFF;
      last_rd[k] = 8'h00;
    end
    @(negedge ph1);
    @(negedge ph1);
    for (int k = 0; k < 3; k++) begin
      check($sformatf("rst%0d ready", k),     16'(ready_s[k]), 16'd0);
      check($sformatf("rst%0d bus_err", k),   16'(err_s[k]),   16'd0);
      check($sformatf("rst%0d rdata", k),     16'(rdata_s[k]), 16'h00);
      check($sformatf("rst%0d io_data", k),   16'(iod_s[k]),   16'h00);
      check($sformatf("rst%0d io_strobe", k), 16'(ios_s[k]),   16'd0);
    end
    for (int k = 0; k < 3; k++) begin
      rst_s[k] = 1'b0;
      req_s[k] = 1'b0;
    end
    rdy_cnt = 0;
    for (int c = 0; c < 4; c++) begin
      @(negedge ph1);
      for (int k = 0; k < 3; k++) if (ready_s[k] === 1'b1) rdy_cnt++;
    end
    check("post_reset no_ready", 16'(rdy_cnt), 16'd0);

    // One wait state: RAM, vectors, illegal writes, unmapped and aliasing addresses.
    access(0, 1'b0, 16'h0010, 8'h5A, 8'h00, 1'b0, 2, 1'b0, "w1 wr_0010");
    access(0, 1'b1, 16'h0010, 8'h00, 8'h5A, 1'b0, 2, 1'b0, "w1 rd_0010");
    access(0, 1'b1, 16'hFFFC, 8'h00, 8'h00, 1'b0, 2, 1'b0, "w1 rd_FFFC");
    access(0, 1'b1, 16'hFFFD, 8'h00, 8'hF0, 1'b0, 2, 1'b0, "w1 rd_FFFD");
    access(0, 1'b0, 16'hFFFC, 8'h12, 8'h00, 1'b1, 2, 1'b0, "w1 wr_FFFC");
    access(0, 1'b1, 16'hFFFC, 8'h00, 8'h00, 1'b0, 2, 1'b0, "w1 rerd_FFFC");
    access(0, 1'b1, 16'h4000, 8'h00, 8'hEA, 1'b1, 2, 1'b0, "w1 rd_4000");
    access(0, 1'b0, 16'h07FF, 8'hA5, 8'h00, 1'b0, 2, 1'b0, "w1 wr_07FF");
    access(0, 1'b1, 16'h07FF, 8'h00, 8'hA5, 1'b0, 2, 1'b0, "w1 rd_07FF");
    access(0, 1'b1, 16'h0800, 8'h00, 8'hEA, 1'b1, 2, 1'b0, "w1 rd_0800");
    access(0, 1'b0, 16'h0000, 8'h3C, 8'h00, 1'b0, 2, 1'b0, "w1 wr_0000");
    access(0, 1'b1, 16'h0010, 8'h00, 8'h5A, 1'b0, 2, 1'b0, "w1 rerd_0010");
    access(0, 1'b1, 16'h0000, 8'h00, 8'h3C, 1'b0, 2, 1'b0, "w1 rd_0000");
`ifdef BUS_RESPONDER_IO_PORT_EN
    access(0, 1'b0, 16'h8000, 8'hC3, 8'h00, 1'b0, 2, 1'b1, "w1 wr_io");
    check("w1 io_data", 16'(iod_s[0]), 16'h00C3);
    access(0, 1'b1, 16'h8000, 8'h00, 8'hC3, 1'b0, 2, 1'b0, "w1 rd_io");
`else
    access(0, 1'b0, 16'h8000, 8'hC3, 8'h00, 1'b1, 2, 1'b0, "w1 wr_io");
    check("w1 io_data", 16'(iod_s[0]), 16'h0000);
    access(0, 1'b1, 16'h8000, 8'h00, 8'hEA, 1'b1, 2, 1'b0, "w1 rd_io");
`endif

    // Three wait states: reset lands in the second WAIT cycle of a write.
    access(1, 1'b0, 16'h0020, 8'h11, 8'h00, 1'b0, 4, 1'b0, "w3 wr_0020");
    req_s[1]   = 1'b1;
    rw_s[1]    = 1'b0;
    addr_s[1]  = 16'h0020;
    wdata_s[1] = 8'h77;
    @(posedge ph1);
    #1;
    req_s[1] = 1'b0;
    rdy_cnt = 0;
    @(negedge ph1);
    if (ready_s[1] === 1'b1) rdy_cnt++;
    @(negedge ph1);
    rst_s[1] = 1'b1;
    @(negedge ph1);
    rst_s[1] = 1'b0;
    last_rd[1] = 8'h00;
    check("w3 rdata_after_reset", 16'(rdata_s[1]), 16'h00);
    for (int c = 0; c < 6; c++) begin
      @(negedge ph1);
      if (ready_s[1] === 1'b1) rdy_cnt++;
    end
    check("w3 aborted no_ready", 16'(rdy_cnt), 16'd0);
    access(1, 1'b1, 16'h0020, 8'h00, 8'h11, 1'b0, 4, 1'b0, "w3 rd_0020");

    // Zero wait states: single accesses, then req held high across six vector reads.
    access(2, 1'b0, 16'h0005, 8'h3C, 8'h00, 1'b0, 1, 1'b0, "w0 wr_0005");
    access(2, 1'b1, 16'h0005, 8'h00, 8'h3C, 1'b0, 1, 1'b0, "w0 rd_0005");
    req_s[2]  = 1'b1;
    rw_s[2]   = 1'b1;
    addr_s[2] = vaddr[0];
    e.rdata = vdat[0];
    e.err   = 1'b0;
    sb_q.push_back(e);
    idx = 0;
    for (int c = 0; c < 12; c++) begin
      @(negedge ph1);
      check($sformatf("w0 hold ready c%0d", c), 16'(ready_s[2]), 16'(c % 2 == 0));
      if (ready_s[2] === 1'b1 && sb_q.size() > 0) begin
        e = sb_q.pop_front();
        check($sformatf("w0 hold rdata c%0d", c), 16'(rdata_s[2]), 16'(e.rdata));
        idx++;
        if (idx < 6) begin
          addr_s[2] = vaddr[idx];
          e.rdata = vdat[idx];
          e.err   = 1'b0;
          sb_q.push_back(e);
        end
      end
    end
    req_s[2] = 1'b0;
    @(negedge ph1);
    check("w0 hold reads done", 16'(idx), 16'd6);

    check("scoreboard drained", 16'(sb_q.size()), 16'd0);
`ifdef BUS_RESPONDER_IO_PORT_EN
    check("w1 strobe count", 16'(strobe_cnt[0]), 16'd1);
`else
    check("w1 strobe count", 16'(strobe_cnt[0]), 16'd0);
`endif
    check("w3 strobe count", 16'(strobe_cnt[1]), 16'd0);
    check("w0 strobe count", 16'(strobe_cnt[2]), 16'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/bus_responder.md
BUS_RESPONDER -- requirements
Module: bus_responder

Interface
REQ-001 Parameter RAM_AWIDTH, default 11: RAM is 2^RAM_AWIDTH bytes, mapped at 0x0000.
REQ-002 Parameter WAIT_CYCLES, default 1: wait states per access; legal range 0..15.
REQ-003 Parameter RESET_VEC, default 16'hF000: value returned for 0xFFFC/0xFFFD.
REQ-004 Parameter NMI_VEC, default 16'hF000: value returned for 0xFFFA/0xFFFB.
REQ-005 Parameter IRQ_VEC, default 16'hF000: value returned for 0xFFFE/0xFFFF.
REQ-006 ph1  in  1  single clock; all state updates on its rising edge.
REQ-007 reset  in  1  synchronous, active-high reset.
REQ-008 req  in  1  CPU access request; held by the CPU until ready.
REQ-009 rw  in  1  1 = read, 0 = write; sampled with req.
REQ-010 addr  in  16  byte address; sampled with req.
REQ-011 wdata  in  8  write data; sampled with req.
REQ-012 rdata  out  8  registered read data; valid only while ready=1 on a read.
REQ-013 ready  out  1  one-cycle completion strobe.
REQ-014 bus_err  out  1  one-cycle strobe coincident with ready on an illegal access.
REQ-015 io_data  out  8  output port register (IO_PORT_EN only; else tied 0x00).
REQ-016 io_strobe  out  1  one-cycle pulse when io_data is written (IO_PORT_EN only; else tied 0).

Function
REQ-017 FSM states IDLE, WAIT, RESP; a 4-bit down-counter sequences WAIT.
REQ-018 IDLE with req=1 at an edge: capture rw/addr/wdata; go to WAIT (counter = WAIT_CYCLES-1), or to RESP if WAIT_CYCLES=0.
REQ-019 WAIT: decrement each cycle; at counter 0 go to RESP.
REQ-020 RESP: ready=1 for exactly this cycle; unconditionally return to IDLE.
REQ-021 Latency: ready is high in the (WAIT_CYCLES+1)th cycle after the accepting edge.
REQ-022 req high during RESP is not a new request; the next access is accepted no earlier than the IDLE cycle after RESP.
REQ-023 req dropping after acceptance does not abort; the captured access completes.
REQ-024 RAM read: rdata = RAM[addr[RAM_AWIDTH-1:0]]; RAM write commits on the edge ending RESP.
REQ-025 Vector read 0xFFFA-0xFFFF: even address returns the low byte, odd the high byte, of the matching parameter.
REQ-026 Unmapped read (not RAM, vector, or enabled IO): rdata=0xEA, bus_err=1.
REQ-027 Write to vector or unmapped address: no state change, bus_err=1.
REQ-028 rdata is held at its last value outside RESP; rdata is not updated on writes.
REQ-029 Address decode uses only the captured address, never live addr.

Reset
REQ-030 reset overrides all other inputs, including a request in the same cycle: state=IDLE, counter=0, ready=0, bus_err=0, rdata=0x00, io_data=0x00, io_strobe=0.
REQ-031 reset mid-access abandons it: no RAM or io_data write, no ready.
REQ-032 RAM contents are not cleared by reset.

Configuration
REQ-033 Macro BUS_RESPONDER_IO_PORT_EN, defined: write to 0x8000 loads io_data and pulses io_strobe in the cycle after RESP; read of 0x8000 returns io_data, bus_err=0.
REQ-034 Macro BUS_RESPONDER_IO_PORT_EN, undefined: 0x8000 is unmapped (REQ-026/027); io_data=0x00 and io_strobe=0.

Verification
REQ-035 WAIT_CYCLES=1: write 0x5A to 0x0010, then read 0x0010 -> each ready 2 cycles after accept; read rdata=0x5A; bus_err=0.
REQ-036 Default params: read 0xFFFC, then 0xFFFD -> rdata 0x00, then 0xF0; write 0x12 to 0xFFFC -> bus_err=1, and a re-read still returns 0x00.
REQ-037 Read 0x4000 (RAM_AWIDTH=11, IO_PORT_EN off) -> rdata=0xEA, bus_err=1 with ready; read 0x0800 aliasing check -> unmapped, 0xEA.
REQ-038 WAIT_CYCLES=3: reset asserted in the second WAIT cycle of a write of 0x77 to 0x0020 -> no ready; a later read of 0x0020 returns the prior contents.
REQ-039 WAIT_CYCLES=0 with req held high continuously -> accesses accepted every other cycle; ready pulses are exactly 1 cycle wide.
REQ-040 IO_PORT_EN defined: write 0xC3 to 0x8000 -> io_strobe pulses 1 cycle after ready; io_data=0xC3; a read of 0x8000 returns 0xC3.
